// File: rtl/clk_tick_pkg.sv
// Shared defaults and the counter-width helper for the clk_tick_gen timebase.
package clk_tick_pkg;

    localparam int DEF_PRE_DIV     = 12;
    localparam int DEF_US_PER_MS   = 1000;
    localparam int DEF_MS_PER_S    = 1000;
    localparam int DEF_DIV_W       = 16;
    localparam int DEF_DIV_DEFAULT = 500;

    // Bits needed to hold 0..modulus-1, never less than one bit.
    function automatic int cnt_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/clk_tick_gen_tick_cnt.sv
// Modulo-MOD counter with a registered wrap pulse and a same-cycle carry for chaining.
// carry is high in the cycle whose edge will wrap the counter, so a following stage
// fed from carry advances on that same edge and its own wrap lines up with this one.
module tick_cnt
    import clk_tick_pkg::*;
#(
    parameter int MOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic carry,
    output logic wrap
);

    localparam int           W    = cnt_w(MOD);
    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt;

    assign carry = inc && (cnt == LAST);

    // Count on inc, wrap at LAST, and register a one-cycle wrap pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= carry;
            if (carry) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// Timebase: 1 us / 1 ms / 1 s clock-enable ticks plus a programmable square wave.
//
// div_ld is a single-cycle strobe with no back-pressure: whenever it is high on an
// edge, div_val is taken (even while en=0 or sync_clr=1). A captured value waits as
// pending until the next square-wave boundary (a toggle, or any microsecond wrap while
// the divisor is 0); a newer strobe before then simply replaces it.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int PRE_DIV     = DEF_PRE_DIV,
    parameter int US_PER_MS   = DEF_US_PER_MS,
    parameter int MS_PER_S    = DEF_MS_PER_S,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DIV_DEFAULT = DEF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             div_ld,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick_us,
    output logic             tick_ms,
    output logic             tick_s,
    output logic             sq_out,
    output logic             sq_edge,
    output logic [DIV_W-1:0] div_cur
);

    logic us_carry;
    logic ms_carry;
    logic s_carry_unused;

    logic [DIV_W-1:0] half_cnt;
    logic [DIV_W-1:0] div_pend;
    logic             pend;

    logic             div_zero;
    logic             half_last;
    logic             boundary;
    logic             ld_pend;
    logic [DIV_W-1:0] ld_val;

    // Prescaler: clk cycles -> microseconds. Held while en=0.
    tick_cnt #(.MOD(PRE_DIV)) u_pre (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .inc   (en),
        .carry (us_carry),
        .wrap  (tick_us)
    );

    // Milliseconds, advancing on the same edge the prescaler wraps.
    tick_cnt #(.MOD(US_PER_MS)) u_ms (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .inc   (us_carry),
        .carry (ms_carry),
        .wrap  (tick_ms)
    );

    // Seconds, advancing on the same edge the ms stage wraps.
    tick_cnt #(.MOD(MS_PER_S)) u_s (
        .clk   (clk),
        .rst   (rst),
        .clr   (sync_clr),
        .inc   (ms_carry),
        .carry (s_carry_unused),
        .wrap  (tick_s)
    );

    // Boundary detection and the divisor value that would be applied this edge.
    always_comb begin
        div_zero  = (div_cur == '0);
        half_last = !div_zero && (half_cnt == div_cur - DIV_W'(1));
        boundary  = us_carry && (div_zero || half_last);
        ld_pend   = div_ld || pend;
        ld_val    = div_ld ? div_val : div_pend;
    end

    // Divisor pending/apply: a strobe on a boundary edge takes effect on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cur  <= DIV_W'(DIV_DEFAULT);
            div_pend <= '0;
            pend     <= 1'b0;
        end else if (boundary && !sync_clr && ld_pend) begin
            div_cur  <= ld_val;
            div_pend <= ld_val;
            pend     <= 1'b0;
        end else begin
            div_pend <= ld_val;
            pend     <= ld_pend;
        end
    end

    // Half-period counter and square wave; a zero divisor parks the wave at its level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half_cnt <= '0;
            sq_out   <= 1'b0;
            sq_edge  <= 1'b0;
        end else if (sync_clr) begin
            half_cnt <= '0;
            sq_out   <= 1'b0;
            sq_edge  <= 1'b0;
        end else begin
            sq_edge <= us_carry && half_last;
            if (us_carry) begin
                if (div_zero || half_last) begin
                    half_cnt <= '0;
                end else begin
                    half_cnt <= half_cnt + DIV_W'(1);
                end
                if (half_last) begin
                    sq_out <= ~sq_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: directed timing scenarios plus a random run,
// all compared against a microsecond-level reference model.
module tb_clk_tick_gen;

    localparam int PRE_DIV     = 12;
    localparam int US_PER_MS   = 4;
    localparam int MS_PER_S    = 3;
    localparam int DIV_W       = 16;
    localparam int DIV_DEFAULT = 5;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sync_clr = 1'b0;
    logic             div_ld = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             tick_us;
    logic             tick_ms;
    logic             tick_s;
    logic             sq_out;
    logic             sq_edge;
    logic [DIV_W-1:0] div_cur;

    always #5 clk = ~clk;

    clk_tick_gen #(
        .PRE_DIV     (PRE_DIV),
        .US_PER_MS   (US_PER_MS),
        .MS_PER_S    (MS_PER_S),
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .div_ld   (div_ld),
        .div_val  (div_val),
        .tick_us  (tick_us),
        .tick_ms  (tick_ms),
        .tick_s   (tick_s),
        .sq_out   (sq_out),
        .sq_edge  (sq_edge),
        .div_cur  (div_cur)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int edge_idx = 0;
    int first_us = -1;
    int first_ms = -1;
    int first_s  = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d, t=%0t)", tag, got, exp, edge_idx, $time);
        end
    endtask

    // ---------------- reference model (microsecond view) ----------------
    // m_n counts enabled clocks since the last clear; every PRE_DIV of them is one us.
    int m_n;
    int m_us_half;
    int m_div;
    int m_pend_val;
    bit m_pend;
    bit m_sq;

    // Expected {div_cur, sq_edge, sq_out, tick_s, tick_ms, tick_us} per edge.
    logic [DIV_W+4:0] exp_q[$];

    task automatic model_reset();
        m_n        = 0;
        m_us_half  = 0;
        m_div      = DIV_DEFAULT;
        m_pend     = 1'b0;
        m_pend_val = 0;
        m_sq       = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit e, input bit c, input bit l, input int v);
        bit t_us;
        bit t_ms;
        bit t_s;
        bit t_edge;
        bit apply;
        t_us = 0; t_ms = 0; t_s = 0; t_edge = 0; apply = 0;
        if (c) begin
            m_n       = 0;
            m_us_half = 0;
            m_sq      = 1'b0;
        end else if (e) begin
            m_n++;
            if (m_n % PRE_DIV == 0) begin
                t_us = 1'b1;
                t_ms = (m_n % (PRE_DIV * US_PER_MS)) == 0;
                t_s  = (m_n % (PRE_DIV * US_PER_MS * MS_PER_S)) == 0;
                if (m_div == 0) begin
                    apply = 1'b1;
                end else begin
                    m_us_half++;
                    if (m_us_half == m_div) begin
                        m_sq      = !m_sq;
                        t_edge    = 1'b1;
                        m_us_half = 0;
                        apply     = 1'b1;
                    end
                end
            end
        end
        if (l) begin
            m_pend     = 1'b1;
            m_pend_val = v;
        end
        if (apply && m_pend) begin
            m_div  = m_pend_val;
            m_pend = 1'b0;
        end
        exp_q.push_back({DIV_W'(m_div), t_edge, m_sq, t_s, t_ms, t_us});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic [DIV_W+4:0] x;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        x = exp_q.pop_front();
        check("tick_us", 32'(tick_us), 32'(x[0]));
        check("tick_ms", 32'(tick_ms), 32'(x[1]));
        check("tick_s",  32'(tick_s),  32'(x[2]));
        check("sq_out",  32'(sq_out),  32'(x[3]));
        check("sq_edge", 32'(sq_edge), 32'(x[4]));
        check("div_cur", 32'(div_cur), 32'(x[DIV_W+4:5]));
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input bit e, input bit c, input bit l, input int v);
        @(negedge clk);
        en       = e;
        sync_clr = c;
        div_ld   = l;
        div_val  = DIV_W'(v);
        @(posedge clk);
        edge_idx++;
        model_step(e, c, l, v);
        #1;
        check_outputs();
        if (tick_us && first_us < 0) first_us = edge_idx;
        if (tick_ms && first_ms < 0) first_ms = edge_idx;
        if (tick_s  && first_s  < 0) first_s  = edge_idx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; sync_clr = 1'b0; div_ld = 1'b0; div_val = '0;
        @(negedge clk);
        model_reset();
        edge_idx = 0;
        first_us = -1; first_ms = -1; first_s = -1;
        rst = 1'b1;
    endtask

    task automatic run_until(input int idx);
        while (edge_idx < idx) cycle(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic next_tick_us(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 0);
            if (tick_us) begin
                at = edge_idx;
                break;
            end
        end
    endtask

    // Reset asserted between edges; outputs must clear before any further edge.
    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_tick_us"}, 32'(tick_us), 32'd0);
        check({tag, "_tick_ms"}, 32'(tick_ms), 32'd0);
        check({tag, "_tick_s"},  32'(tick_s),  32'd0);
        check({tag, "_sq_out"},  32'(sq_out),  32'd0);
        check({tag, "_sq_edge"}, 32'(sq_edge), 32'd0);
        check({tag, "_div_cur"}, 32'(div_cur), 32'(DIV_DEFAULT));
        @(negedge clk);
        model_reset();
        edge_idx = 0;
        first_us = -1; first_ms = -1; first_s = -1;
        rst = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int at;
        int edges;

        // Reset applied before any clock edge has happened.
        #2;
        rst = 1'b0;
        #1;
        check("por_tick_us", 32'(tick_us), 32'd0);
        check("por_sq_out",  32'(sq_out),  32'd0);
        check("por_div_cur", 32'(div_cur), 32'(DIV_DEFAULT));
        do_reset();

        // First us/ms/s ticks from reset release.
        run_until(150);
        check("first_tick_us", 32'(first_us), 32'd12);
        check("first_tick_ms", 32'(first_ms), 32'd48);
        check("first_tick_s",  32'(first_s),  32'd144);

        // Divisor 3 loaded 2 us into a 5 us half: this half still 5 us, then 3 us halves.
        do_reset();
        run_until(24);
        cycle(1'b1, 1'b0, 1'b1, 3);
        run_until(59);
        check("ld3_div_before", 32'(div_cur), 32'd5);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("ld3_edge60",   32'(sq_edge), 32'd1);
        check("ld3_sq60",     32'(sq_out),  32'd1);
        check("ld3_div_after", 32'(div_cur), 32'd3);
        run_until(95);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("ld3_edge96", 32'(sq_edge), 32'd1);
        check("ld3_sq96",   32'(sq_out),  32'd0);

        // en low for 7 cycles mid-prescale delays the next tick by exactly 7.
        do_reset();
        run_until(5);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 0);
        next_tick_us(30, at);
        check("en_pause_tick", 32'(at), 32'd19);

        // Divisor 0 freezes the wave; divisor 2 applies on the next us wrap.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 0);
        run_until(60);
        check("zero_sq60",  32'(sq_out),  32'd1);
        check("zero_div60", 32'(div_cur), 32'd0);
        edges = 0;
        while (edge_idx < 124) begin
            cycle(1'b1, 1'b0, 1'b0, 0);
            if (sq_edge) edges++;
        end
        check("zero_no_edges", 32'(edges), 32'd0);
        check("zero_sq_held", 32'(sq_out), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 2);
        run_until(131);
        check("ld2_div_before", 32'(div_cur), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("ld2_div132",  32'(div_cur), 32'd2);
        check("ld2_edge132", 32'(sq_edge), 32'd0);
        run_until(155);
        check("ld2_edge155", 32'(sq_edge), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 0);
        check("ld2_edge156", 32'(sq_edge), 32'd1);
        check("ld2_sq156",   32'(sq_out),  32'd0);

        // sync_clr keeps the divisor and restarts the prescaler.
        run_until(185);
        cycle(1'b1, 1'b1, 1'b0, 0);
        check("clr_sq",      32'(sq_out),  32'd0);
        check("clr_div",     32'(div_cur), 32'd2);
        check("clr_tick_us", 32'(tick_us), 32'd0);
        next_tick_us(30, at);
        check("clr_next_tick", 32'(at), 32'd198);

        // Asynchronous reset in mid-operation with a non-default divisor in force.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 2);
        run_until(70);
        async_reset_check("arst");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit e;
            bit c;
            bit l;
            int v;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 29) == 0);
            v = $urandom_range(0, 6);
            cycle(e, c, l, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
